// File: rtl/mp_add_sub_seq.sv
// Multi-precision add/subtract sequencer: streams operands one byte per clock,
// LSB first, through a shared 8-bit add_sub datapath and chains the carry.

module add_sub (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] bx;

    // b is conditionally inverted by cin; callers pre-XOR b to undo this
    assign bx = b ^ {8{cin}};
    assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
endmodule

module mp_add_sub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [8*NBYTES-1:0] A,
    input  logic [8*NBYTES-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] Result,
    output logic                Cout,
    output logic                Ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-9:0]  res_sr;
    logic [W-1:0]  res_cat;
    logic [IW-1:0] idx;
    logic          op_q;
    logic          c;
    logic          last;

    logic [7:0]    dp_b;
    logic [7:0]    dp_sum;
    logic          dp_cout;
    logic          ovf_next;

    assign last = (idx == IW'(NBYTES - 1));
    assign dp_b = b_sr[7:0] ^ {8{op_q ^ c}};

    add_sub u_add_sub (
        .a    (a_sr[7:0]),
        .b    (dp_b),
        .cin  (c),
        .sum  (dp_sum),
        .cout (dp_cout)
    );

    assign res_cat = {dp_sum, res_sr};

    // On the last byte a_sr/b_sr hold the operand MSB bytes
    always_comb begin
        if (op_q)
            ovf_next = (a_sr[7] != b_sr[7]) && (dp_sum[7] != a_sr[7]);
        else
            ovf_next = (a_sr[7] == b_sr[7]) && (dp_sum[7] != a_sr[7]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last)
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            idx    <= '0;
            op_q   <= 1'b0;
            c      <= 1'b0;
            Result <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        op_q <= op;
                        idx  <= '0;
                        c    <= op;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 8;
                    b_sr   <= b_sr >> 8;
                    res_sr <= res_cat[W-1:8];
                    c      <= dp_cout;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        Result <= res_cat;
                        Cout   <= dp_cout;
                        Ovf    <= ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_sub_seq.sv
// Directed bench for mp_add_sub_seq at NBYTES=4.

module tb_mp_add_sub_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        Cout;
    logic        Ovf;

    int tests;
    int fails;

    mp_add_sub_seq #(.NBYTES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Cout   (Cout),
        .Ovf    (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation and follows it back to IDLE (bounded).
    // lat = cycle index (1 = cycle after accept edge) of the done pulse, 0 if none.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = ~o; A = ~a; B = ~b;
        lat = 0;
        busy_cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cyc++;
            if (done) lat = n;
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 1'b0; A = 32'h1234_5678; B = 32'h1111_1111;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, Result, Cout, Ovf} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b Result=%h Cout=%b Ovf=%b, want all 0",
                     busy, done, Result, Cout, Ovf);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        logic [31:0] va [4] = '{32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        logic [31:0] vr [4] = '{32'h0100_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, va[i], vb[i], lat, bc);
            tests++;
            if (lat != 5 || bc != 5) begin
                fails++;
                $display("FAIL add_timing[%0d]: done_cycle=%0d busy_cycles=%0d, want 5 5", i, lat, bc);
            end
            tests++;
            if (Result !== vr[i] || Cout !== vc[i] || Ovf !== vo[i]) begin
                fails++;
                $display("FAIL add_result[%0d]: Result=%h Cout=%b Ovf=%b, want %h %b %b",
                         i, Result, Cout, Ovf, vr[i], vc[i], vo[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] va [4] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h0000_0005};
        logic [31:0] vb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
        logic [31:0] vr [4] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        logic        vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        vo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, va[i], vb[i], lat, bc);
            tests++;
            if (lat != 5 || Result !== vr[i] || Cout !== vc[i] || Ovf !== vo[i]) begin
                fails++;
                $display("FAIL sub_result[%0d]: done_cycle=%0d Result=%h Cout=%b Ovf=%b, want 5 %h %b %b",
                         i, lat, Result, Cout, Ovf, vr[i], vc[i], vo[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int  dones;
        logic seen;
        dones = 0;
        seen  = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'h1111_1111; B = 32'h2222_2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; A = 32'hFFFF_FFFF; B = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (done) begin
                seen = 1'b1;
                dones++;
                start = 1'b1; op = 1'b1; A = 32'h0; B = 32'h0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (!seen || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ignore_done_start: seen=%b busy=%b done=%b, want 1 0 0", seen, busy, done);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests++;
        if (dones != 1 || Result !== 32'h3333_3333 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result: dones=%0d Result=%h Cout=%b Ovf=%b, want 1 33333333 0 0",
                     dones, Result, Cout, Ovf);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, dones;
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc);
        tests++;
        if (Result !== 32'h0 || Cout !== 1'b1 || Ovf !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup: Result=%h Cout=%b Ovf=%b, want 00000000 1 1", Result, Cout, Ovf);
        end
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'h0102_0304; B = 32'h1010_1010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: busy=%b done=%b Result=%h Cout=%b Ovf=%b, want 0 0 0 0 0",
                     busy, done, Result, Cout, Ovf);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests++;
        if (dones != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: dones=%0d busy=%b, want 0 0", dones, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 32'h1234_5678, 32'h0234_5678, lat, bc);
        tests++;
        if (lat != 5 || Result !== 32'h1000_0000 || Cout !== 1'b1 || Ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: done_cycle=%0d Result=%h Cout=%b Ovf=%b, want 5 10000000 1 0",
                     lat, Result, Cout, Ovf);
        end
    endtask

    task automatic test_reset_vs_start();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 1'b0; A = 32'h1; B = 32'h1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_beats_start: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_abort();
        test_reset_vs_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
